// File: rtl/pipe_mult8.sv
// Pipelined unsigned WIDTH x WIDTH multiplier returning the low WIDTH product bits.
// Each stage folds one WIDTH/STAGES-bit multiplier digit into a running partial sum.
module pipe_mult8 #(
   parameter int WIDTH  = 64,
   parameter int STAGES = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] mcand,
   input  logic [WIDTH-1:0] mplier,
   input  logic             start,
   output logic [WIDTH-1:0] product,
   output logic             done
);

   localparam int DIG_W = WIDTH / STAGES;

   // Multiply by one digit and accumulate, discarding everything above WIDTH bits.
   function automatic logic [WIDTH-1:0] mac_trunc(input logic [WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0] mc,
                                                  input logic [DIG_W-1:0] dig);
      logic [WIDTH-1:0] part;
      part = mc * {{(WIDTH-DIG_W){1'b0}}, dig};
      return acc + part;
   endfunction

   logic [WIDTH-1:0]  acc_p [0:STAGES-1];
   logic [WIDTH-1:0]  mc_p  [0:STAGES-2];
   logic [WIDTH-1:0]  mp_p  [0:STAGES-2];
   logic [STAGES-1:0] vld_p;

   // Stage 1 latches the operands at issue; later stages consume one digit each.
   always_ff @(posedge clock) begin
      acc_p[0] <= mac_trunc('0, mcand, mplier[DIG_W-1:0]);
      mc_p[0]  <= mcand << DIG_W;
      mp_p[0]  <= mplier >> DIG_W;
      for (int s = 1; s < STAGES; s++) begin
         acc_p[s] <= mac_trunc(acc_p[s-1], mc_p[s-1], mp_p[s-1][DIG_W-1:0]);
      end
      for (int s = 1; s < STAGES - 1; s++) begin
         mc_p[s] <= mc_p[s-1] << DIG_W;
         mp_p[s] <= mp_p[s-1] >> DIG_W;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         vld_p <= '0;
      end else begin
         vld_p <= {vld_p[STAGES-2:0], start};
      end
   end

   // Output register: product only moves on a retiring operation.
   always_ff @(posedge clock) begin
      if (reset) begin
         done    <= 1'b0;
         product <= '0;
      end else begin
         done <= vld_p[STAGES-1];
         if (vld_p[STAGES-1]) begin
            product <= acc_p[STAGES-1];
         end
      end
   end

endmodule

// File: tb/tb_pipe_mult8.sv
// Directed-vector bench for pipe_mult8: latency, wrap, throughput, reset and hold behaviour.
module tb_pipe_mult8;

   logic        clock = 1'b0;
   logic        reset;
   logic [63:0] mcand;
   logic [63:0] mplier;
   logic        start;
   logic [63:0] product;
   logic        done;

   int vec_cnt = 0;
   int err_cnt = 0;

   pipe_mult8 #(.WIDTH(64), .STAGES(8)) dut (
      .clock   (clock),
      .reset   (reset),
      .mcand   (mcand),
      .mplier  (mplier),
      .start   (start),
      .product (product),
      .done    (done)
   );

   always #5 clock = ~clock;

   task automatic chk_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic scramble();
      mcand  = {$urandom, $urandom};
      mplier = {$urandom, $urandom};
   endtask

   // Issue one op, then watch done/product for the following 9 edges.
   task automatic run_one(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input logic [63:0] prev);
      mcand = a; mplier = b; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         scramble();
         step();
         chk_vec({tag, "_done"}, {63'd0, done}, (k == 8) ? 64'd1 : 64'd0);
         chk_vec({tag, "_prod"}, product, (k >= 8) ? exp : prev);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
      step();
      start = 1'b1; mcand = 64'd5; mplier = 64'd5;
      step();
      chk_vec("rst_done", {63'd0, done}, 64'd0);
      chk_vec("rst_prod", product, 64'd0);
      reset = 1'b0; start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         chk_vec("rst_idle_done", {63'd0, done}, 64'd0);
      end

      run_one("basic", 64'd3, 64'd5, 64'd15, 64'd0);
      run_one("carry32", 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 64'd15);
      run_one("sq2_32", 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 64'hFFFF_FFFE_0000_0001);
      run_one("wrap_msb", 64'h8000_0000_0000_0000, 64'd2, 64'd0, 64'd0);
      run_one("wrap_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);

      // Back-to-back issues with operands changing every cycle.
      for (int k = 0; k < 3; k++) begin
         mcand = 64'(k + 2); mplier = 64'(k + 2); start = 1'b1;
         step();
      end
      start = 1'b0;
      for (int k = 3; k <= 11; k++) begin
         scramble();
         step();
         chk_vec("b2b_done", {63'd0, done}, (k >= 8 && k <= 10) ? 64'd1 : 64'd0);
         chk_vec("b2b_prod", product,
                 (k < 8) ? 64'd1 : (k == 8) ? 64'd4 : (k == 9) ? 64'd9 : 64'd16);
      end

      // Reset five edges after issuing 7x7, with a 9x9 issue on the reset edge.
      mcand = 64'd7; mplier = 64'd7; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         scramble();
         step();
         chk_vec("mid_pre_done", {63'd0, done}, 64'd0);
      end
      reset = 1'b1; start = 1'b1; mcand = 64'd9; mplier = 64'd9;
      step();
      reset = 1'b0; start = 1'b0;
      chk_vec("mid_rst_prod", product, 64'd0);
      for (int k = 0; k < 12; k++) begin
         scramble();
         step();
         chk_vec("mid_post_done", {63'd0, done}, 64'd0);
         chk_vec("mid_post_prod", product, 64'd0);
      end
      run_one("after_rst", 64'd6, 64'd6, 64'd36, 64'd0);

      // Bubble hold: 10x10, three idle cycles, then 11x11.
      mcand = 64'd10; mplier = 64'd10; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         scramble();
         step();
      end
      mcand = 64'd11; mplier = 64'd11; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 5; k <= 14; k++) begin
         scramble();
         step();
         chk_vec("bub_done", {63'd0, done}, (k == 8 || k == 12) ? 64'd1 : 64'd0);
         chk_vec("bub_prod", product, (k < 8) ? 64'd36 : (k < 12) ? 64'd100 : 64'd121);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
